// File: rtl/uart_rx_param_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg: shared definitions for the UART receive path (and future uart_tx).
//   uart_state_t         receiver FSM state encoding
//   DEFAULT_CLKS_PER_BIT 100 MHz / 115200 baud
//   MAX_DATA_W           widest supported data word
//   calc_parity()        XOR-reduction of a data word, zero-extended to
//                        MAX_DATA_W (zero padding leaves the parity unchanged)
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned MAX_DATA_W           = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/uart_rx_param_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff: generic two-flop synchroniser for asynchronous inputs.
//   clk      system clock
//   rst      synchronous active-high reset, loads RST_VAL into both flops
//   i_async  asynchronous input
//   o_sync   synchronised output (two clk cycles of latency)
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_param.sv
// ----------------------------------------------------------------------------
// uart_rx_param: parametrised oversampling UART receiver, LSB first.
//   clk         system clock
//   rst         synchronous active-high reset (aborts any frame in flight)
//   rx_in       asynchronous serial line, idle high
//   rx_data     last correctly framed word
//   rx_valid    one-cycle pulse, rx_data updated in the same cycle
//   frame_err   one-cycle pulse, stop bit sampled low (rx_data kept)
//   parity_err  one-cycle pulse alongside rx_valid on parity mismatch
//               (port exists only with UART_RX_PARITY_EN)
//   busy        high whenever the FSM is not IDLE
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit after the data.
// ----------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_W       = 8,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
`ifdef UART_RX_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic              w_rx_s;
    uart_state_t       r_state;
    logic [CNT_W-1:0]  r_clk_cnt;
    logic [BIT_W-1:0]  r_bit_idx;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_frame_err;
    logic              r_parity_err;
    logic              r_par_bit;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx_in),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_par_bit    <= 1'b0;
        end else begin
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state   <= START;
                        r_clk_cnt <= '0;
                    end
                end
                START: begin
                    // Re-check the line at mid start bit: a high here is a glitch.
                    if (r_clk_cnt == HALF_M1) begin
                        if (w_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= DATA;
                            r_clk_cnt <= '0;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_clk_cnt == FULL_M1) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx_s, r_shift[DATA_W-1:1]};
                        if (r_bit_idx == LAST_BIT) begin
                            r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= PARITY;
`else
                            r_state   <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_clk_cnt == FULL_M1) begin
                        r_clk_cnt <= '0;
                        r_par_bit <= w_rx_s;
                        r_state   <= STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (r_clk_cnt == FULL_M1) begin
                        r_clk_cnt <= '0;
                        if (w_rx_s) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= (calc_parity(MAX_DATA_W'(r_shift)) ^ r_par_bit) != PARITY_ODD;
`endif
                            r_state    <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high so a break is not
                    // decoded as a run of zero frames.
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    logic w_unused_par;
    assign w_unused_par = PARITY_ODD ^ r_par_bit ^ r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

    localparam int unsigned CPB = 16;
    localparam int unsigned DW  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif
    localparam bit          PODD       = 1'b0;
    localparam int unsigned FRAME_BITS = DW + 2 + P;
    localparam int unsigned LATENCY    = 2 + CPB / 2 + (DW + 1 + P) * CPB + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_in = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    uart_rx_param #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DW),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_ferr;
        logic [DW-1:0] data;
        logic          perr;
    } exp_t;

    exp_t         exp_q[$];
    int unsigned  valid_cyc[$];
    int unsigned  cyc = 0;
    int unsigned  errors = 0;
    int unsigned  checks = 0;
    int unsigned  n_valid = 0;
    int unsigned  n_ferr = 0;
    int unsigned  n_pulse = 0;
    int unsigned  n_valid_exp = 0;
    int unsigned  t_start = 0;
    logic [DW-1:0] last_good = '0;
    logic          prev_valid = 1'b0;
    logic          prev_ferr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic good_par(input logic [DW-1:0] d);
        return (^d) ^ PODD;
    endfunction

    task automatic expect_valid(input logic [DW-1:0] d, input logic perr);
        exp_t e;
        e.is_ferr = 1'b0;
        e.data    = d;
        e.perr    = perr;
        exp_q.push_back(e);
        n_valid_exp++;
    endtask

    task automatic expect_ferr();
        exp_t e;
        e.is_ferr = 1'b1;
        e.data    = '0;
        e.perr    = 1'b0;
        exp_q.push_back(e);
    endtask

    // Drives one frame starting at a negedge; returns at the negedge where
    // the stop bit ends, leaving the line at the stop value.
    task automatic send(input logic [DW-1:0] d, input logic par, input logic stop);
        t_start = cyc;
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < int'(DW); i++) begin
            rx_in = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (P != 0) begin
            rx_in = par;
            repeat (CPB) @(negedge clk);
        end
        rx_in = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic drain(input int unsigned bound);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || busy) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_idle", busy, 1'b0);
    endtask

    // Scoreboard: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (rx_valid || frame_err)) begin
            n_pulse++;
            chk("no_overlap", rx_valid & frame_err, 1'b0);
            chk("pulse_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_ferr) begin
                    n_ferr++;
                    chk("ferr_kind", frame_err, 1'b1);
                    chk("ferr_keeps_data", rx_data, last_good);
                end else begin
                    n_valid++;
                    chk("valid_kind", rx_valid, 1'b1);
                    chk("rx_data", rx_data, e.data);
`ifdef UART_RX_PARITY_EN
                    chk("parity_err", parity_err, e.perr);
`endif
                    last_good = e.data;
                    valid_cyc.push_back(cyc);
                end
            end
        end
        if (!rst && rx_valid) chk("valid_one_cycle", prev_valid, 1'b0);
        if (!rst && frame_err) chk("ferr_one_cycle", prev_ferr, 1'b0);
        prev_valid = rx_valid;
        prev_ferr  = frame_err;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int unsigned got;
        int unsigned pulses_before;

        // Reset state
        @(negedge clk);
        rst = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_rx_data", rx_data, '0);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
`ifdef UART_RX_PARITY_EN
        chk("reset_parity_err", parity_err, 1'b0);
`endif
        repeat (4) @(negedge clk);

        // Single frame 0xA5 and its latency
        expect_valid(8'hA5, 1'b0);
        base = valid_cyc.size();
        send(8'hA5, good_par(8'hA5), 1'b1);
        drain(200);
        chk("a5_valid_count", valid_cyc.size() - base, 1);
        got = (valid_cyc.size() > base) ? valid_cyc[base] - t_start : 0;
        chk("a5_latency", got, LATENCY);
        repeat (5) @(negedge clk);

        // Start-bit glitch of 5 cycles
        pulses_before = n_pulse;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy_high", busy, 1'b1);
        @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_busy_low", busy, 1'b0);
        chk("glitch_no_pulse", n_pulse, pulses_before);

        // Framing error, then a long low, then recovery
        expect_ferr();
        send(8'h3C, good_par(8'h3C), 1'b0);
        pulses_before = n_pulse;
        repeat (40) @(negedge clk);
        chk("break_busy", busy, 1'b1);
        chk("break_no_pulse", n_pulse, pulses_before);
        chk("break_queue_empty", exp_q.size(), 0);
        rx_in = 1'b1;
        repeat (8) @(negedge clk);
        chk("break_released", busy, 1'b0);
        expect_valid(8'h81, 1'b0);
        send(8'h81, good_par(8'h81), 1'b1);
        drain(200);

        // Back-to-back frames with no idle gap
        base = valid_cyc.size();
        expect_valid(8'h00, 1'b0);
        expect_valid(8'hFF, 1'b0);
        expect_valid(8'h55, 1'b0);
        send(8'h00, good_par(8'h00), 1'b1);
        send(8'hFF, good_par(8'hFF), 1'b1);
        send(8'h55, good_par(8'h55), 1'b1);
        drain(200);
        chk("b2b_count", valid_cyc.size() - base, 3);
        if (valid_cyc.size() >= base + 3) begin
            chk("b2b_gap1", valid_cyc[base + 1] - valid_cyc[base], FRAME_BITS * CPB);
            chk("b2b_gap2", valid_cyc[base + 2] - valid_cyc[base + 1], FRAME_BITS * CPB);
        end

`ifdef UART_RX_PARITY_EN
        // Wrong then correct parity bit for 0x07
        expect_valid(8'h07, 1'b1);
        send(8'h07, 1'b0, 1'b1);
        drain(200);
        expect_valid(8'h07, 1'b0);
        send(8'h07, 1'b1, 1'b1);
        drain(200);
`endif

        // Reset in the middle of data bit 4
        pulses_before = n_pulse;
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_in = i[0];
            repeat (CPB) @(negedge clk);
        end
        rx_in = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        chk("mid_frame_busy", busy, 1'b1);
        rst = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_rx_data", rx_data, '0);
        chk("midrst_rx_valid", rx_valid, 1'b0);
        chk("midrst_frame_err", frame_err, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        last_good = '0;
        repeat (3 * FRAME_BITS * CPB) @(negedge clk);
        chk("midrst_no_pulse", n_pulse, pulses_before);
        expect_valid(8'h12, 1'b0);
        send(8'h12, good_par(8'h12), 1'b1);
        drain(200);

        // Totals
        chk("total_valid", n_valid, n_valid_exp);
        chk("total_ferr", n_ferr, 1);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
